cfg_load_ctrl: RTL and testbench

- Loads a complete driver-monitor configuration profile into the configuration register block.
- The profile is 4 sensor weights plus the warning and emergency thresholds.
- Bytes arrive on a valid/ready byte stream from the host interface. They are buffered in a shadow store and checked for consistency, then committed as an atomic burst of write cycles on the cfg_we / cfg_addr / wght_data write port.
- Sits between the host command decoder and the configuration register block, and is the only writer of that port.

---
 rtl/cfg_pkg.sv | 37 +++
 rtl/cfg_timeout_cnt.sv | 36 +++
 rtl/cfg_load_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cfg_load_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration profile loader:
// FSM states, register-block addresses and failure codes.
package cfg_pkg;

    localparam int NUM_CFG = 6;
    localparam int IDX_W   = $clog2(NUM_CFG);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT,
        DONE
    } cfg_state_e;

    typedef enum logic [3:0] {
        ADDR_W0   = 4'd0,
        ADDR_W1   = 4'd1,
        ADDR_W2   = 4'd2,
        ADDR_W3   = 4'd3,
        ADDR_WARN = 4'd4,
        ADDR_EMER = 4'd5
    } cfg_addr_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_THRESH  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_code_e;

    // Profile bytes are written zero-extended onto the 16-bit data bus.
    function automatic logic [15:0] mk_wdata(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/cfg_timeout_cnt.sv
// Clearable saturating inter-byte counter. tc_o flags the cycle whose
// increment brings the count up to LIMIT.
module cfg_timeout_cnt #(
    parameter int LIMIT = 1000,
    parameter int W     = 10
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != W'(LIMIT))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = inc_i && !clr_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/cfg_load_ctrl.sv
// Buffers a 6-byte driver-monitor profile from a byte stream, checks the
// thresholds, then commits it as an uninterruptible burst of register writes.
module cfg_load_ctrl
    import cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        cfg_we,
    output logic [3:0]  cfg_addr,
    output logic [15:0] wght_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);

    cfg_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       shadow_q [NUM_CFG];
    logic             s_ready_q;
    logic             cfg_we_q;
    logic [3:0]       cfg_addr_q;
    logic [15:0]      wdata_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    err_code_e        err_code_q;

    logic             accept;
    logic             to_clr;
    logic             to_inc;
    logic             to_tc;
    logic [IDX_W-1:0] idx_inc;

    assign accept  = s_valid && s_ready_q;
    assign idx_inc = idx_q + IDX_W'(1);
    assign to_clr  = (state_q != LOAD) || accept;
    assign to_inc  = (state_q == LOAD);

    cfg_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC),
        .W     (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n_i (rst),
        .clr_i   (to_clr),
        .inc_i   (to_inc),
        .tc_o    (to_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            s_ready_q  <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_addr_q <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        idx_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    // Abort wins over a byte offered in the same cycle.
                    if (abort) begin
                        state_q    <= IDLE;
                        s_ready_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_ABORT;
                    end else if (accept) begin
                        shadow_q[idx_q] <= s_data;
                        if (idx_q == LAST_IDX) begin
                            state_q   <= CHECK;
                            s_ready_q <= 1'b0;
                            idx_q     <= '0;
                        end else begin
                            idx_q <= idx_inc;
                        end
                    end else if (to_tc) begin
                        state_q    <= IDLE;
                        s_ready_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                CHECK: begin
                    if (shadow_q[IDX_W'(ADDR_EMER)] > shadow_q[IDX_W'(ADDR_WARN)]) begin
                        state_q    <= COMMIT;
                        idx_q      <= '0;
                        cfg_we_q   <= 1'b1;
                        cfg_addr_q <= ADDR_W0;
                        wdata_q    <= mk_wdata(shadow_q[0]);
                    end else begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_THRESH;
                    end
                end
                COMMIT: begin
                    // The write port already carries entry idx_q; stage the next one.
                    if (idx_q == LAST_IDX) begin
                        state_q    <= DONE;
                        idx_q      <= '0;
                        cfg_we_q   <= 1'b0;
                        cfg_addr_q <= '0;
                        wdata_q    <= '0;
                        done_q     <= 1'b1;
                    end else begin
                        idx_q      <= idx_inc;
                        cfg_addr_q <= 4'(idx_inc);
                        wdata_q    <= mk_wdata(shadow_q[idx_inc]);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    idx_q     <= '0;
                    s_ready_q <= 1'b0;
                    cfg_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign cfg_we    = cfg_we_q;
    assign cfg_addr  = cfg_addr_q;
    assign wght_data = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_cfg_load_ctrl.sv
// Randomized bench for cfg_load_ctrl: profiles are sent over the byte stream
// and the observed write burst / pulses are compared with the profile rules.
module tb_cfg_load_ctrl;

    localparam int T = 1000;
    typedef logic [7:0] prof_t [6];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] wght_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    cfg_load_ctrl #(.TIMEOUT_CYC(T), .TO_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .wght_data (wght_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;
    int model_ec = 0;

    // Observation of the write port and status pulses, sampled mid-cycle.
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int done_cnt, done_cyc, err_cnt, err_cyc, err_code_seen, idle_junk;
    bit busy_hist [int];

    always @(negedge clk) begin
        busy_hist[cyc] = busy;
        if (cfg_we) begin
            wr_addr_q.push_back(int'(cfg_addr));
            wr_data_q.push_back(int'(wght_data));
            wr_cyc_q.push_back(cyc);
        end else if (cfg_addr != 4'd0 || wght_data != 16'd0) begin
            idle_junk++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            err_code_seen = int'(err_code);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt = 0;
        err_cnt = 0;
        done_cyc = -1;
        err_cyc = -1;
        err_code_seen = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte and hold it until the handshake, bounded.
    task automatic send_byte(input logic [7:0] b, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        s_valid = 1'b1;
        s_data = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = cyc;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("byte_accept", int'(ok), 1);
    endtask

    task automatic do_load(input prof_t p, input int gap_max, input bit start_mid, output int n_last);
        int acc;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, gap_max));
            if (start_mid && i == 3) pulse_start();
            send_byte(p[i], acc);
        end
        n_last = acc;
    endtask

    // Expected outcome follows directly from the profile: emer > warn commits
    // all six bytes in order, anything else is a threshold failure.
    task automatic expect_outcome(input string name, input prof_t p, input int n, input int pulse_kind);
        bit pass;
        pass = (p[5] > p[4]);
        while (cyc < n + 12) begin
            abort = (pulse_kind == 1 && cyc == n + 4);
            start = (pulse_kind == 2 && cyc == n + 4);
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        start = 1'b0;
        if (pass) begin
            chk({name, "_wr_count"}, wr_addr_q.size(), 6);
            for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
                chk({name, "_wr_addr"}, wr_addr_q[i], i);
                chk({name, "_wr_data"}, wr_data_q[i], int'({8'h00, p[i]}));
                chk({name, "_wr_cyc"}, wr_cyc_q[i], n + 2 + i);
            end
            chk({name, "_done_cnt"}, done_cnt, 1);
            chk({name, "_done_cyc"}, done_cyc, n + 8);
            chk({name, "_err_cnt"}, err_cnt, 0);
            chk({name, "_busy_done"}, int'(busy_hist[n + 8]), 1);
            chk({name, "_busy_idle"}, int'(busy_hist[n + 9]), 0);
        end else begin
            model_ec = 1;
            chk({name, "_wr_count"}, wr_addr_q.size(), 0);
            chk({name, "_err_cnt"}, err_cnt, 1);
            chk({name, "_err_cyc"}, err_cyc, n + 2);
            chk({name, "_err_code"}, err_code_seen, 1);
            chk({name, "_busy_chk"}, int'(busy_hist[n + 1]), 1);
            chk({name, "_busy_after"}, int'(busy_hist[n + 2]), 0);
            chk({name, "_done_cnt"}, done_cnt, 0);
        end
        chk({name, "_err_code_hold"}, int'(err_code), model_ec);
        chk({name, "_busy_end"}, int'(busy), 0);
        $display("[%0d] %s: prof=%h %h %h %h %h %h pass=%0d writes=%0d done=%0d err=%0d",
                 cyc, name, p[0], p[1], p[2], p[3], p[4], p[5], pass,
                 wr_addr_q.size(), done_cnt, err_cnt);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_s_ready"}, int'(s_ready), 0);
        chk({name, "_cfg_we"}, int'(cfg_we), 0);
        chk({name, "_cfg_addr"}, int'(cfg_addr), 0);
        chk({name, "_wdata"}, int'(wght_data), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_err"}, int'(err), 0);
        chk({name, "_err_code"}, int'(err_code), 0);
    endtask

    initial begin
        prof_t p;
        int n, acc, a;

        idle_junk = 0;
        clr_mon();
        #3;
        chk_all_zero("reset");
        $display("[%0d] reset: outputs checked while rst low", cyc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Happy path
        clr_mon();
        p = '{8'h05, 8'hFE, 8'h01, 8'h07, 8'h64, 8'hB4};
        do_load(p, 0, 1'b0, n);
        expect_outcome("happy", p, n, 0);

        // Threshold failures, strict and equal
        clr_mon();
        p = '{8'h02, 8'h03, 8'h01, 8'h04, 8'hB4, 8'h64};
        do_load(p, 0, 1'b0, n);
        expect_outcome("thr_low", p, n, 0);
        clr_mon();
        p = '{8'h02, 8'h03, 8'h01, 8'h04, 8'h80, 8'h80};
        do_load(p, 0, 1'b0, n);
        expect_outcome("thr_eq", p, n, 0);

        // Timeout after three bytes
        clr_mon();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), acc);
        n = acc;
        while (cyc < n + T + 6) idle(1);
        model_ec = 2;
        chk("tmo_err_cnt", err_cnt, 1);
        chk("tmo_err_cyc", err_cyc, n + T + 1);
        chk("tmo_err_code", err_code_seen, 2);
        chk("tmo_wr_count", wr_addr_q.size(), 0);
        chk("tmo_busy_last", int'(busy_hist[n + T]), 1);
        chk("tmo_busy_after", int'(busy_hist[n + T + 1]), 0);
        $display("[%0d] timeout: last byte cyc %0d err at %0d code %0d", cyc, n, err_cyc, err_code_seen);

        // Gap one short of the limit still completes
        clr_mon();
        p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h10, 8'h20};
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(p[i], acc);
        n = acc;
        idle(T - 1);
        send_byte(p[3], acc);
        chk("gap_accept_cyc", acc, n + T);
        send_byte(p[4], acc);
        send_byte(p[5], acc);
        expect_outcome("gap_tm1", p, acc, 0);

        // Abort together with the 4th byte
        clr_mon();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), acc);
        s_valid = 1'b1;
        s_data = 8'hA5;
        abort = 1'b1;
        @(negedge clk);
        a = cyc;
        chk("abt_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        abort = 1'b0;
        idle(10);
        model_ec = 3;
        chk("abt_err_cnt", err_cnt, 1);
        chk("abt_err_cyc", err_cyc, a + 1);
        chk("abt_err_code", err_code_seen, 3);
        chk("abt_wr_count", wr_addr_q.size(), 0);
        chk("abt_busy", int'(busy_hist[a + 1]), 0);
        $display("[%0d] abort_in_load: abort cyc %0d err code %0d", cyc, a, err_code_seen);

        // Abort during commit, then start during load and commit
        clr_mon();
        p = '{8'h05, 8'hFE, 8'h01, 8'h07, 8'h64, 8'hB4};
        do_load(p, 0, 1'b0, n);
        expect_outcome("abort_commit", p, n, 1);
        clr_mon();
        p = '{8'h9C, 8'h7F, 8'h80, 8'h01, 8'h30, 8'hF0};
        do_load(p, 2, 1'b1, n);
        expect_outcome("start_ign", p, n, 2);

        // Asynchronous reset after three commit writes
        clr_mon();
        p = '{8'h05, 8'hFE, 8'h01, 8'h07, 8'h64, 8'hB4};
        do_load(p, 0, 1'b0, n);
        while (cyc < n + 5) idle(1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("arst");
        chk("arst_wr_count", wr_addr_q.size(), 3);
        model_ec = 0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        $display("[%0d] async_reset: writes before reset %0d", cyc, wr_addr_q.size());
        clr_mon();
        do_load(p, 1, 1'b0, n);
        expect_outcome("post_reset", p, n, 0);

        // Randomized profiles, gaps and ignored/ineffective control pulses
        for (int r = 0; r < 12; r++) begin
            clr_mon();
            for (int i = 0; i < 6; i++) p[i] = 8'($urandom);
            do_load(p, 3, 1'($urandom_range(0, 1)), n);
            expect_outcome($sformatf("rand%0d", r), p, n, $urandom_range(0, 2));
        end

        chk("idle_port_zero", idle_junk, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
